bumpy_move: RTL
===============

# bumpy_move

Per-frame motion engine for the Bumpy ball, directly upstream of `step_controller`. It produces the ball-centre position `bumpy_x`/`bumpy_y` that `step_controller` converts to grid indices, and consumes the four neighbour tile types (`area`) returned for that position. From these it resolves gravity, bounce, wall and hazard collisions once per video frame, and reports death and gate arrival to the level FSM.

## Interface

**Parameters**
- `SPAWN_X` (96), `SPAWN_Y` (96): ball centre after reset or `lvl_start`.
- `R` (16): ball radius in px.
- `GRAVITY` (1): px/frame² added to `vy` each frame.
- `BOUNCE_V` (14): upward speed after a floor bounce.
- `VMAX` (15): maximum downward `vy`; must stay below `R` so a tile edge cannot be skipped.
- `HSPEED` (3): horizontal px/frame while a key is held.
- `SCREEN_W` (640), `SCREEN_H` (448): playfield size.

**Ports**
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `startOfFrame` in 1: one-cycle pulse per frame; the physics tick.
- `lvl_start` in 1: one-cycle pulse; respawn and enter play.
- `left_key`, `right_key` in 1: level-held keys.
- `area` in [3:0][2:0]: neighbour tile types of the tile containing the centre. Index 0 = left, 1 = up, 2 = right, 3 = down.
- `bumpy_x`, `bumpy_y` out 11: ball centre in px.
- `vy` out 6 signed: vertical speed (debug and sprite squash).
- `playing` out 1: high in PLAY.
- `dead` out 1: high in DEAD.
- `level_done` out 1: one-cycle pulse on entry to WIN.

## Operation

**Tile grid**
- Tiles are 64 px. `col = bumpy_x>>6`, `row = bumpy_y>>6`.
- Tile codes: FREE=0, REGU=1, GATE=2, DEATH=3, WALL=4, SPIKE=5.
- Solid tiles are REGU, GATE and WALL.

**State machine**
- IDLE: entered from reset; waits for `lvl_start`.
- PLAY: `lvl_start` from any state loads `x=SPAWN_X`, `y=SPAWN_Y`, `vy=0` and enters PLAY.
- DEAD and WIN: hold position; leave only on `lvl_start`.

**Physics (PLAY only, on `startOfFrame`)**
- Horizontal:
  - `right_key` alone: `x += HSPEED`. If `x+R+HSPEED >= (col+1)*64` and `area[2]==WALL`, clamp `x = (col+1)*64-R-1`. Also clamp to `x <= SCREEN_W-1-R`.
  - `left_key` alone: mirror of the above, using `area[0]` and a lower clamp of `x >= R`.
  - Both keys or no key: no horizontal move.
- Vertical:
  - Update speed first: `vn = min(vy+GRAVITY, VMAX)`.
  - Down crossing, when `vn>0` and `y+R+vn >= (row+1)*64`, resolved by `area[3]`:
    - REGU or WALL: `y = (row+1)*64-R`, `vy = -BOUNCE_V`.
    - GATE: clamp `y` as for REGU, `vy = 0`, go to WIN.
    - SPIKE or DEATH: clamp `y` as for REGU, `vy = 0`, go to DEAD.
    - FREE: `y += vn`, `vy = vn`.
  - Up crossing, when `vn<0` and `y-R+vn < row*64` with `area[1]` solid: `y = row*64+R`, `vy = 0`.
  - Ceiling: if `y-R+vn < 0`, then `y = R`, `vy = 0`.
  - Falling off the bottom: if `y-R >= SCREEN_H` after the update, go to DEAD.
- Horizontal and vertical updates use the same sampled `area`, then commit together in one cycle.

**Arithmetic**
- Intermediates are 12-bit signed, so no wrap occurs.

## Timing

- Reset values: `bumpy_x=SPAWN_X`, `bumpy_y=SPAWN_Y`, `vy=0`, `playing=0`, `dead=0`, `level_done=0`, state IDLE.
- Position, `vy` and state update in the cycle after `startOfFrame`; latency is 1 clock.
- `area` is sampled in the `startOfFrame` cycle. It is valid because position only changes once per frame and `step_controller` settles within 2 clocks.
- Output timing on state changes:
  - `playing` and `dead` are registered and change in the same cycle as the state.
  - `level_done` is high for exactly the one cycle after the WIN transition.
- Boundary and simultaneous-event rules:
  - `lvl_start` together with `startOfFrame`: respawn wins, no physics that frame.
  - `startOfFrame` in IDLE, DEAD or WIN: ignored.
  - `resetN` low mid-frame: immediate return to the reset values.

## Structure

- `bumpy_pkg` holds the tile-code constants, `TILE_SHIFT=6`, a `bumpy_state_t` enum (IDLE, PLAY, DEAD, WIN), and the screen dimensions. `step_controller` shares the same package.
- One combinational sub-module, `bumpy_collide`, takes `x`, `y`, `vy`, the keys and `area`, and returns next `x`/`y`/`vy` plus `hit_gate`/`hit_hazard`.
- `bumpy_move` keeps the FSM and the registers.

## Test plan

- **Drop and bounce:** reset, `lvl_start`, `area[3]=REGU`, other entries FREE, no keys, 6 ticks. Expect `y` = 97, 99, 102, 106, 111, then 112 with `vy=-14`. The next tick gives `y=99`, `vy=-13`.
- **Right wall:** `x=100`, `right_key`, `area[2]=WALL`. Expect ticks to give 103, 106, …, then a clamp at 111 that holds. With `area[2]=FREE`, motion continues past 112.
- **Spike:** `area[3]=SPIKE` at spawn. After 6 ticks expect `y=112`, `dead=1`, `playing=0`. Further ticks leave `x`/`y` unchanged.
- **Gate:** `area[3]=GATE`. Expect `level_done` high for exactly 1 cycle, then WIN. A following `lvl_start` returns to (96,96), `vy=0`, PLAY.
- **Fall off screen:** all-FREE `area` from `y=420`. Expect DEAD once `y-16 >= 448`.
- **Priority and reset:** `lvl_start` coincident with `startOfFrame` gives the spawn position with no physics applied. `resetN` pulsed mid-play gives (96,96), IDLE, all flags 0.

Source files
------------

// File: rtl/bumpy_pkg.sv
// bumpy_pkg: constants shared by the Bumpy motion engine and step_controller.
//   - tile codes, tile size (TILE_SHIFT), playfield size
//   - neighbour index of each direction inside `area`
//   - game state enum and a helper that classifies solid tiles
package bumpy_pkg;

  localparam int TILE_SHIFT = 6;
  localparam int TILE_PX    = 1 << TILE_SHIFT;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 448;

  localparam logic [2:0] T_FREE  = 3'd0;
  localparam logic [2:0] T_REGU  = 3'd1;
  localparam logic [2:0] T_GATE  = 3'd2;
  localparam logic [2:0] T_DEATH = 3'd3;
  localparam logic [2:0] T_WALL  = 3'd4;
  localparam logic [2:0] T_SPIKE = 3'd5;

  localparam int A_LEFT  = 0;
  localparam int A_UP    = 1;
  localparam int A_RIGHT = 2;
  localparam int A_DOWN  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2,
    WIN  = 2'd3
  } bumpy_state_t;

  function automatic logic is_solid(input logic [2:0] t);
    return (t == T_REGU) || (t == T_GATE) || (t == T_WALL);
  endfunction

endpackage

// File: rtl/bumpy_move_if.sv
// bumpy_move_if: frame/keys/tile inputs and position/status outputs of the
// motion engine.
//   master : level logic side (drives frame tick, keys, neighbour tiles)
//   slave  : bumpy_move side (drives position, vy and status flags)
interface bumpy_move_if;

  logic              startOfFrame;
  logic              lvl_start;
  logic              left_key;
  logic              right_key;
  logic [3:0][2:0]   area;

  logic [10:0]       bumpy_x;
  logic [10:0]       bumpy_y;
  logic signed [5:0] vy;
  logic              playing;
  logic              dead;
  logic              level_done;

  modport master (
    output startOfFrame, lvl_start, left_key, right_key, area,
    input  bumpy_x, bumpy_y, vy, playing, dead, level_done
  );

  modport slave (
    input  startOfFrame, lvl_start, left_key, right_key, area,
    output bumpy_x, bumpy_y, vy, playing, dead, level_done
  );

endinterface

// File: rtl/bumpy_collide.sv
// bumpy_collide: combinational one-frame physics step.
//   x_i, y_i, vy_i       : current ball centre and vertical speed
//   left_key_i/right_key_i: held keys
//   area_i               : neighbour tiles (left, up, right, down)
//   x_o, y_o, vy_o       : position and speed for the next frame
//   hit_gate_o           : landed on a gate tile
//   hit_hazard_o         : landed on spike/death or fell below the playfield
module bumpy_collide
  import bumpy_pkg::*;
#(
  parameter int R        = 16,
  parameter int GRAVITY  = 1,
  parameter int BOUNCE_V = 14,
  parameter int VMAX     = 15,
  parameter int HSPEED   = 3,
  parameter int SCR_W    = SCREEN_W,
  parameter int SCR_H    = SCREEN_H
) (
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  input  logic signed [5:0] vy_i,
  input  logic              left_key_i,
  input  logic              right_key_i,
  input  logic [3:0][2:0]   area_i,
  output logic [10:0]       x_o,
  output logic [10:0]       y_o,
  output logic signed [5:0] vy_o,
  output logic              hit_gate_o,
  output logic              hit_hazard_o
);

  localparam logic signed [11:0] R_S      = 12'(R);
  localparam logic signed [11:0] G_S      = 12'(GRAVITY);
  localparam logic signed [11:0] VMAX_S   = 12'(VMAX);
  localparam logic signed [11:0] HS_S     = 12'(HSPEED);
  localparam logic signed [11:0] BOUNCE_S = 12'(-BOUNCE_V);
  localparam logic signed [11:0] XMAX_S   = 12'(SCR_W - 1 - R);
  localparam logic signed [11:0] H_S      = 12'(SCR_H);
  localparam logic signed [11:0] TILE_S   = 12'(TILE_PX);

  logic signed [11:0] xs, ys, vys;
  logic signed [11:0] x_lo, x_hi, y_lo, y_hi;
  logic signed [11:0] vsum, vn;
  logic signed [11:0] xn, yn, vyn;
  logic               gate, hazard;

  // Positions are non-negative, so the zero-extended 12-bit view is safe.
  assign xs  = {1'b0, x_i};
  assign ys  = {1'b0, y_i};
  assign vys = {{6{vy_i[5]}}, vy_i};

  assign x_lo = (xs >>> TILE_SHIFT) <<< TILE_SHIFT;
  assign x_hi = x_lo + TILE_S;
  assign y_lo = (ys >>> TILE_SHIFT) <<< TILE_SHIFT;
  assign y_hi = y_lo + TILE_S;

  assign vsum = vys + G_S;
  assign vn   = (vsum > VMAX_S) ? VMAX_S : vsum;

  always_comb begin
    xn = xs;
    if (right_key_i && !left_key_i) begin
      xn = xs + HS_S;
      if ((xs + R_S + HS_S >= x_hi) && (area_i[A_RIGHT] == T_WALL))
        xn = x_hi - R_S - 12'sd1;
      if (xn > XMAX_S)
        xn = XMAX_S;
    end else if (left_key_i && !right_key_i) begin
      xn = xs - HS_S;
      if ((xs - R_S - HS_S < x_lo) && (area_i[A_LEFT] == T_WALL))
        xn = x_lo + R_S;
      if (xn < R_S)
        xn = R_S;
    end
  end

  always_comb begin
    yn     = ys + vn;
    vyn    = vn;
    gate   = 1'b0;
    hazard = 1'b0;

    if ((vn > 12'sd0) && (ys + R_S + vn >= y_hi)) begin
      case (area_i[A_DOWN])
        T_REGU, T_WALL: begin
          yn  = y_hi - R_S;
          vyn = BOUNCE_S;
        end
        T_GATE: begin
          yn   = y_hi - R_S;
          vyn  = '0;
          gate = 1'b1;
        end
        T_SPIKE, T_DEATH: begin
          yn     = y_hi - R_S;
          vyn    = '0;
          hazard = 1'b1;
        end
        default: ;
      endcase
    end

    if ((vn < 12'sd0) && (ys - R_S + vn < y_lo) && is_solid(area_i[A_UP])) begin
      yn  = y_lo + R_S;
      vyn = '0;
    end

    if (ys - R_S + vn < 12'sd0) begin
      yn  = R_S;
      vyn = '0;
    end

    // Dropping out of the bottom of the playfield is fatal as well.
    if (yn - R_S >= H_S)
      hazard = 1'b1;
  end

  assign x_o          = 11'(xn);
  assign y_o          = 11'(yn);
  assign vy_o         = 6'(vyn);
  assign hit_gate_o   = gate;
  assign hit_hazard_o = hazard;

endmodule

// File: rtl/bumpy_move.sv
// bumpy_move: per-frame motion engine for the Bumpy ball.
//   clk, resetN : clock, asynchronous active-low reset
//   bus (slave) : frame tick, level start, keys, neighbour tiles in;
//                 ball centre, vy, playing/dead/level_done out
// Physics runs once per startOfFrame while in PLAY; lvl_start respawns from
// any state and takes priority over the frame tick.
module bumpy_move
  import bumpy_pkg::*;
#(
  parameter int SPAWN_X  = 96,
  parameter int SPAWN_Y  = 96,
  parameter int R        = 16,
  parameter int GRAVITY  = 1,
  parameter int BOUNCE_V = 14,
  parameter int VMAX     = 15,
  parameter int HSPEED   = 3,
  parameter int SCR_W    = SCREEN_W,
  parameter int SCR_H    = SCREEN_H
) (
  input  logic         clk,
  input  logic         resetN,
  bumpy_move_if.slave  bus
);

  bumpy_state_t      state_q;
  logic [10:0]       x_q, y_q;
  logic signed [5:0] vy_q;
  logic              playing_q, dead_q, level_done_q;

  logic [10:0]       x_d, y_d;
  logic signed [5:0] vy_d;
  logic              hit_gate, hit_hazard;

  bumpy_collide #(
    .R        (R),
    .GRAVITY  (GRAVITY),
    .BOUNCE_V (BOUNCE_V),
    .VMAX     (VMAX),
    .HSPEED   (HSPEED),
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H)
  ) u_collide (
    .x_i          (x_q),
    .y_i          (y_q),
    .vy_i         (vy_q),
    .left_key_i   (bus.left_key),
    .right_key_i  (bus.right_key),
    .area_i       (bus.area),
    .x_o          (x_d),
    .y_o          (y_d),
    .vy_o         (vy_d),
    .hit_gate_o   (hit_gate),
    .hit_hazard_o (hit_hazard)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      x_q          <= 11'(SPAWN_X);
      y_q          <= 11'(SPAWN_Y);
      vy_q         <= '0;
      playing_q    <= 1'b0;
      dead_q       <= 1'b0;
      level_done_q <= 1'b0;
    end else begin
      level_done_q <= 1'b0;
      if (bus.lvl_start) begin
        state_q   <= PLAY;
        x_q       <= 11'(SPAWN_X);
        y_q       <= 11'(SPAWN_Y);
        vy_q      <= '0;
        playing_q <= 1'b1;
        dead_q    <= 1'b0;
      end else if ((state_q == PLAY) && bus.startOfFrame) begin
        x_q  <= x_d;
        y_q  <= y_d;
        vy_q <= vy_d;
        if (hit_hazard) begin
          state_q   <= DEAD;
          playing_q <= 1'b0;
          dead_q    <= 1'b1;
        end else if (hit_gate) begin
          state_q      <= WIN;
          playing_q    <= 1'b0;
          level_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bumpy_x    = x_q;
  assign bus.bumpy_y    = y_q;
  assign bus.vy         = vy_q;
  assign bus.playing    = playing_q;
  assign bus.dead       = dead_q;
  assign bus.level_done = level_done_q;

endmodule
